// File: rtl/decode_queue.sv
// decode_queue -- RV32I decode-at-enqueue instruction queue.
//
// Incoming instruction words are decoded at enqueue time and the decoded
// fields (not the raw word) are stored in a DEPTH-entry circular FIFO.
// The head entry drives the outputs combinationally from storage; every
// head field reads 0 while the queue is empty.
//
// Parameters:
//   DEPTH     : number of entries (power of two, >= 2)
//   DROP_ZERO : when 1, the all-zero word is a bubble. Its handshake
//               completes, but it is never enqueued.
//
// Optional feature (macro DECODE_QUEUE_ILLEGAL_EN):
//   Adds output 'illegal' for the head entry. Unsupported opcodes and R-type
//   words with a bad funct7 are flagged. They are still enqueued, with
//   RegWrite and BMS forced to 0.
//
// Ports:
//   clk, rst_n (async active-low), flush (sync clear)
//   in_valid / in_ready / instruction : enqueue handshake
//   out_valid / out_ready              : dequeue handshake
//   opcode, rd, rs1, rs2, func3, imm   : head decoded fields
//   LoadStore, ALUSrc, RegWrite, ALUControl, BMS : head control signals
//   count                              : occupancy
`timescale 1ns/1ps

module decode_queue #(
  parameter int DEPTH     = 4,
  parameter int DROP_ZERO = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instruction,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [6:0]             opcode,
  output logic [4:0]             rd,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic [2:0]             func3,
  output logic [31:0]            imm,
  output logic                   LoadStore,
  output logic                   ALUSrc,
  output logic                   RegWrite,
  output logic [3:0]             ALUControl,
  output logic                   BMS,
`ifdef DECODE_QUEUE_ILLEGAL_EN
  output logic                   illegal,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_AND   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  func3;
    logic [31:0] imm;
    logic        load_store;
    logic        alu_src;
    logic        reg_write;
    logic [3:0]  alu_ctl;
    logic        bms;
`ifdef DECODE_QUEUE_ILLEGAL_EN
    logic        illegal;
`endif
  } entry_t;

  function automatic entry_t decode(input logic [31:0] w);
    entry_t     e;
    logic [3:0] alu_base;
    e          = '0;
    e.opcode   = w[6:0];
    e.rd       = w[11:7];
    e.func3    = w[14:12];
    e.rs1      = w[19:15];
    e.rs2      = w[24:20];
    // Base operation from func3; the [30] alternates are applied per opcode.
    unique case (w[14:12])
      3'b000:  alu_base = ALU_ADD;
      3'b001:  alu_base = ALU_SLL;
      3'b010:  alu_base = ALU_SLT;
      3'b011:  alu_base = ALU_SLTU;
      3'b100:  alu_base = ALU_XOR;
      3'b101:  alu_base = ALU_SRL;
      3'b110:  alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
    case (w[6:0])
      OP_R: begin
        e.reg_write = 1'b1;
        e.alu_ctl   = alu_base;
        if (w[30] && w[14:12] == 3'b000) e.alu_ctl = ALU_SUB;
        if (w[30] && w[14:12] == 3'b101) e.alu_ctl = ALU_SRA;
      end
      OP_I: begin
        e.alu_src   = 1'b1;
        e.reg_write = 1'b1;
        e.imm       = {{20{w[31]}}, w[31:20]};
        // addi has no subtract form, so only the shift uses [30].
        e.alu_ctl   = (w[30] && w[14:12] == 3'b101) ? ALU_SRA : alu_base;
      end
      OP_LD: begin
        e.load_store = 1'b1;
        e.alu_src    = 1'b1;
        e.reg_write  = 1'b1;
        e.imm        = {{20{w[31]}}, w[31:20]};
        e.alu_ctl    = ALU_ADD;
      end
      OP_ST: begin
        e.load_store = 1'b1;
        e.alu_src    = 1'b1;
        e.bms        = 1'b1;
        e.imm        = {{20{w[31]}}, w[31:25], w[11:7]};
        e.alu_ctl    = ALU_ADD;
      end
      OP_LUI: begin
        e.alu_src   = 1'b1;
        e.reg_write = 1'b1;
        e.imm       = {w[31:12], 12'b0};
        e.alu_ctl   = ALU_PASSB;
      end
      default: e.alu_ctl = ALU_ADD;
    endcase
`ifdef DECODE_QUEUE_ILLEGAL_EN
    if (!(w[6:0] inside {OP_R, OP_I, OP_LD, OP_ST, OP_LUI}) ||
        (w[6:0] == OP_R && w[31:25] != 7'b0000000 && w[31:25] != 7'b0100000)) begin
      e.illegal   = 1'b1;
      e.reg_write = 1'b0;
      e.bms       = 1'b0;
    end
`endif
    return e;
  endfunction

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_push;
  logic            w_pop;
  logic            w_bubble;
  entry_t          w_dec;
  entry_t          w_head;

  assign in_ready  = (r_count < DEPTH_C);
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  // A bubble still completes its handshake; it just never reaches storage.
  assign w_bubble  = (DROP_ZERO != 0) && (instruction == 32'd0);
  assign w_push    = in_valid && in_ready && !flush && !w_bubble;
  assign w_pop     = out_valid && out_ready && !flush;
  assign w_dec     = decode(instruction);

  // Control state: flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only; occupancy gating makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_dec;
  end

  assign w_head     = out_valid ? r_mem[r_rd_ptr] : '0;

  assign opcode     = w_head.opcode;
  assign rd         = w_head.rd;
  assign rs1        = w_head.rs1;
  assign rs2        = w_head.rs2;
  assign func3      = w_head.func3;
  assign imm        = w_head.imm;
  assign LoadStore  = w_head.load_store;
  assign ALUSrc     = w_head.alu_src;
  assign RegWrite   = w_head.reg_write;
  assign ALUControl = w_head.alu_ctl;
  assign BMS        = w_head.bms;
`ifdef DECODE_QUEUE_ILLEGAL_EN
  assign illegal    = w_head.illegal;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue -- self-checking bench for decode_queue.
// A queue of raw accepted words models occupancy/order; expected head fields
// are derived from the RV32I field definitions at compare time.
`timescale 1ns/1ps

module tb_decode_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  func3;
  logic [31:0] imm;
  logic        LoadStore, ALUSrc, RegWrite, BMS;
  logic [3:0]  ALUControl;
  logic [$clog2(DEPTH):0] count;
`ifdef DECODE_QUEUE_ILLEGAL_EN
  logic        illegal;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];

  decode_queue #(.DEPTH(DEPTH), .DROP_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .func3(func3), .imm(imm),
    .LoadStore(LoadStore), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .BMS(BMS),
`ifdef DECODE_QUEUE_ILLEGAL_EN
    .illegal(illegal),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic        ls, asrc, rw;
    logic [3:0]  alu;
    logic        bms;
    logic        ill;
  } exp_t;

  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t e;
    int   alu_of_f3 [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    bit   is_r   = (w[6:0] == 7'h33);
    bit   is_i   = (w[6:0] == 7'h13);
    bit   is_ld  = (w[6:0] == 7'h03);
    bit   is_st  = (w[6:0] == 7'h23);
    bit   is_lui = (w[6:0] == 7'h37);
    logic [11:0] i12;
    logic [11:0] s12;
    i12 = w[31:20];
    s12 = {w[31:25], w[11:7]};
    e = '0;
    e.op  = w[6:0];
    e.rd  = w[11:7];
    e.f3  = w[14:12];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    if (is_i || is_ld) e.imm = 32'($signed(i12));
    else if (is_st)    e.imm = 32'($signed(s12));
    else if (is_lui)   e.imm = w & 32'hFFFF_F000;
    e.ls   = is_ld || is_st;
    e.asrc = is_i || is_ld || is_st || is_lui;
    e.rw   = is_r || is_i || is_ld || is_lui;
    e.bms  = is_st;
    if (is_lui) e.alu = 4'd10;
    else if (is_r || is_i) begin
      e.alu = 4'(alu_of_f3[w[14:12]]);
      if (w[30] && w[14:12] == 3'd5) e.alu = 4'd7;
      if (w[30] && w[14:12] == 3'd0 && is_r) e.alu = 4'd1;
    end else e.alu = 4'd0;
    e.ill = !(is_r || is_i || is_ld || is_st || is_lui) ||
            (is_r && w[31:25] != 7'h00 && w[31:25] != 7'h20);
`ifdef DECODE_QUEUE_ILLEGAL_EN
    if (e.ill) begin
      e.rw  = 1'b0;
      e.bms = 1'b0;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference queue update at each edge, from sampled inputs.
  always @(posedge clk) begin
    if (!rst_n || flush) mq.delete();
    else begin
      bit do_pop, do_push;
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && (mq.size() < DEPTH) && (instruction != 32'd0);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(instruction);
    end
  end

  // Per-cycle comparison against the reference, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    e = (mq.size() != 0) ? ref_dec(mq[0]) : '0;
    chk("count",      32'(count),      32'(mq.size()));
    chk("in_ready",   32'(in_ready),   32'(mq.size() < DEPTH));
    chk("out_valid",  32'(out_valid),  32'(mq.size() != 0));
    chk("opcode",     32'(opcode),     32'(e.op));
    chk("rd",         32'(rd),         32'(e.rd));
    chk("rs1",        32'(rs1),        32'(e.rs1));
    chk("rs2",        32'(rs2),        32'(e.rs2));
    chk("func3",      32'(func3),      32'(e.f3));
    chk("imm",        imm,             e.imm);
    chk("LoadStore",  32'(LoadStore),  32'(e.ls));
    chk("ALUSrc",     32'(ALUSrc),     32'(e.asrc));
    chk("RegWrite",   32'(RegWrite),   32'(e.rw));
    chk("ALUControl", 32'(ALUControl), 32'(e.alu));
    chk("BMS",        32'(BMS),        32'(e.bms));
`ifdef DECODE_QUEUE_ILLEGAL_EN
    chk("illegal",    32'(illegal),    32'(e.ill));
`endif
  end

  task automatic step(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
    in_valid    = iv;
    instruction = ins;
    out_ready   = ordy;
    flush       = fl;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom();
    k = $urandom_range(0, 9);
    case (k)
      0: w = 32'd0;
      1: begin w[6:0] = 7'h33; w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
      2: w[6:0] = 7'h33;
      3, 4: w[6:0] = 7'h13;
      5: w[6:0] = 7'h03;
      6: w[6:0] = 7'h23;
      7: w[6:0] = 7'h37;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_imm",       imm,            32'd0);
    rst_n = 1'b1;

    // ori x5, x0, 0x9a
    step(1, 32'h09a06293, 0, 0);
    chk("ori_valid",  32'(out_valid),  32'd1);
    chk("ori_opcode", 32'(opcode),     32'h13);
    chk("ori_rd",     32'(rd),         32'd5);
    chk("ori_rs1",    32'(rs1),        32'd0);
    chk("ori_func3",  32'(func3),      32'd6);
    chk("ori_imm",    imm,             32'h9a);
    chk("ori_alu",    32'(ALUControl), 32'd8);
    chk("ori_asrc",   32'(ALUSrc),     32'd1);
    chk("ori_rw",     32'(RegWrite),   32'd1);
    step(0, 0, 1, 0);

    // Bubble dropped, then three real instructions in FIFO order.
    step(1, 32'h00000000, 0, 0);
    chk("bubble_count", 32'(count), 32'd0);
    step(1, 32'h00106313, 0, 0);
    step(1, 32'h00730e33, 0, 0);
    step(1, 32'h01ce0eb3, 0, 0);
    chk("seq_count", 32'(count), 32'd3);
    chk("seq1_rd",  32'(rd),  32'd6);
    chk("seq1_imm", imm,      32'd1);
    step(0, 0, 1, 0);
    chk("seq2_rd",  32'(rd),  32'd28);
    chk("seq2_rs1", 32'(rs1), 32'd6);
    chk("seq2_rs2", 32'(rs2), 32'd7);
    chk("seq2_alu", 32'(ALUControl), 32'd0);
    step(0, 0, 1, 0);
    chk("seq3_rd",  32'(rd),  32'd29);
    chk("seq3_rs1", 32'(rs1), 32'd28);
    chk("seq3_rs2", 32'(rs2), 32'd28);
    step(0, 0, 1, 0);
    chk("seq_empty", 32'(out_valid), 32'd0);

    // Fill to full; fifth word refused; full + popping still not ready.
    for (int i = 0; i < 4; i++) step(1, 32'h00100093 + (i << 7), 0, 0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count",    32'(count),    32'd4);
    step(1, 32'h00500113, 0, 0);
    chk("fifth_count",   32'(count),    32'd4);
    in_valid = 1'b1; out_ready = 1'b1; instruction = 32'h00700193;
    #1;
    chk("full_pop_in_ready", 32'(in_ready), 32'd0);
    step(1, 32'h00700193, 1, 0);
    chk("full_pop_count", 32'(count), 32'd3);

    // Streaming through pointer wrap at constant occupancy.
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h00000013 | (32'(i + 1) << 20) | (32'(i + 1) << 7), 1, 0);
      chk("stream_count", 32'(count), 32'd3);
    end
    repeat (4) step(0, 0, 1, 0);

    // sw x5, 8(x2), then flush with a simultaneous push.
    step(1, 32'h00512423, 0, 0);
    chk("sw_ls",  32'(LoadStore), 32'd1);
    chk("sw_bms", 32'(BMS),       32'd1);
    chk("sw_rw",  32'(RegWrite),  32'd0);
    chk("sw_imm", imm,            32'd8);
    step(1, 32'h00100093, 0, 1);
    chk("flush_count", 32'(count),     32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset between edges with two entries held.
    step(1, 32'h00100093, 0, 0);
    step(1, 32'h00200113, 0, 0);
    chk("pre_rst_count", 32'(count), 32'd2);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    mq.delete();
    #1;
    chk("async_valid",    32'(out_valid), 32'd0);
    chk("async_count",    32'(count),     32'd0);
    chk("async_in_ready", 32'(in_ready),  32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1, 32'h00106313, 0, 0);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_rd",    32'(rd),    32'd6);

    // Randomized traffic against the reference queue.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0);
    end
    step(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: the clock is clk and the reset is rst_n.
REQ-002 The block SHALL have parameter DEPTH (default 4, meaning queue entries, a power of two of at least 2).
REQ-003 The block SHALL have parameter DROP_ZERO (default 1; when 1, instruction 32'h00000000 is a bubble and is never enqueued).
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock, rising edge.
- rst_n, in, 1, async active-low reset.
- flush, in, 1, synchronous queue clear.
- in_valid, in, 1, instruction offered.
- in_ready, out, 1, queue can accept.
- instruction, in, 32, RV32I instruction word.
- out_valid, out, 1, head entry present.
- out_ready, in, 1, consumer takes head.
- opcode, out, 7, head opcode field.
- rd, out, 5, head rd field.
- rs1, out, 5, head rs1 field.
- rs2, out, 5, head rs2 field.
- func3, out, 3, head func3 field.
- imm, out, 32, head sign-extended immediate.
- LoadStore, out, 1, head is a load or store.
- ALUSrc, out, 1, head ALU operand B is imm.
- RegWrite, out, 1, head writes rd.
- ALUControl, out, 4, head ALU operation.
- BMS, out, 1, head is a store (memory write).
- count, out, $clog2(DEPTH)+1, occupancy.

Function
REQ-005 Decode SHALL happen at enqueue and store the decoded fields, not the raw word.
REQ-006 Fields SHALL be extracted as follows: opcode=[6:0], rd=[11:7], func3=[14:12], rs1=[19:15], rs2=[24:20].
REQ-007 imm SHALL be formed per opcode:
- I-type (0010011, 0000011): sext [31:20].
- S-type (0100011): sext {[31:25],[11:7]}.
- U-type (0110111): {[31:12],12'b0}.
- All other opcodes: 0.
REQ-008 ALUControl SHALL use this encoding: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, PASSB 1010.
- R-type selects SUB/SRA when [30]=1.
- I-type selects SRA when func3=101 and [30]=1.
- Load, store and other opcodes select ADD; LUI selects PASSB.
REQ-009 The control outputs SHALL decode as follows:
- LoadStore=1 for opcode 0000011 or 0100011.
- ALUSrc=1 for I-ALU, load, store or LUI.
- RegWrite=1 for R, I-ALU, load or LUI.
- BMS=1 only for opcode 0100011.
REQ-010 Push SHALL occur when in_valid&in_ready and not flush, and not (DROP_ZERO and instruction==0).
REQ-011 Pop SHALL occur when out_valid&out_ready and not flush.
REQ-012 in_ready SHALL equal (count<DEPTH); push and pop in the same cycle SHALL leave count unchanged.
REQ-013 A full queue with a pop in progress SHALL still drive in_ready=0, because in_ready does not depend on out_ready.
REQ-014 out_valid SHALL equal (count!=0); the head fields SHALL be driven from the storage array, and all head fields SHALL be 0 when the queue is empty.
REQ-015 Latency SHALL be one cycle: a word accepted at edge N into an empty queue is visible at the outputs after edge N.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH.
REQ-017 flush SHALL set count and both pointers to 0 at the next edge and SHALL override any push or pop in that cycle.
REQ-018 A dropped zero word SHALL be consumed (the handshake completes) without changing count.

Reset
REQ-019 Asserting rst_n=0 SHALL, asynchronously, set count, the pointers and out_valid to 0, set in_ready to 1, and set all head outputs to 0.
REQ-020 Reset asserted mid-operation SHALL discard all entries, and the first edge after release SHALL accept input normally.

Configuration
REQ-021 Macro DECODE_QUEUE_ILLEGAL_EN SHALL control illegal-instruction detection.
- Defined: add output illegal (1 bit, head entry), set when the opcode is not one of the five supported opcodes or when R-type [31:25] is not 0000000/0100000; illegal entries are still enqueued, with RegWrite=0 and BMS=0 forced.
- Undefined: no illegal port, and unsupported opcodes decode per REQ-007 to REQ-009 with no forcing.

Verification
REQ-022 Reset, then push 09a06293 with out_ready=0, SHALL give out_valid=1 next cycle with opcode=0010011, rd=5, rs1=0, func3=110, imm=0x9A, ALUControl=1000, ALUSrc=1, RegWrite=1.
REQ-023 Pushing 00000000, 00106313, 00730e33 and 01ce0eb3 (DROP_ZERO=1) SHALL give count=3, then pops in order SHALL show rd=6 imm=1, then rd=28 rs1=6 rs2=7 ALUControl=0000, then rd=29 rs1=28 rs2=28.
REQ-024 Five pushes with DEPTH=4 and out_ready=0 SHALL give in_ready=0 after four, the fifth word not enqueued, and count=4.
REQ-025 Continuous push and pop for 10 cycles through pointer wrap SHALL hold count constant and present outputs in FIFO order.
REQ-026 Store 0x00512423 (sw x5,8(x2)) SHALL give LoadStore=1, BMS=1, RegWrite=0, imm=8; flush with a simultaneous push SHALL then give count=0 and out_valid=0.
REQ-027 Driving rst_n low between clock edges with count=2 SHALL immediately give out_valid=0, count=0 and in_ready=1.
